ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
// - Consumer side of the main decoder's control bundle: carries the decoded control bits from ID through EX, MEM and WB.
// - Resolves load-use hazards (stall plus bubble) and branch/jump redirects (IF/ID flush).
// - Generates the EX-stage operand forwarding selects.
// - Sits between the opcode decoder/ID stage and the datapath pipeline registers of the 5-stage CPU.
// PARAMETERS
// - RA_W     5  register-address width
// - ALUOP_W  2  width of the ALUOp field
// PORTS
// - clk_i          in   1        clock, rising edge
// - rst_i          in   1        async active-high reset
// - RegDst_i       in   1        decoder bundle (ID); may be X when don't-care
// - ALUSrc_i       in   1        decoder bundle
// - MemtoReg_i     in   1        decoder bundle
// - RegWrite_i     in   1        decoder bundle
// - MemWrite_i     in   1        decoder bundle
// - MemRead_i      in   1        decoder bundle
// - ALUOp_i        in   ALUOP_W  decoder bundle
// - id_rs_i        in   RA_W     rs field of the instruction in ID
// - id_rt_i        in   RA_W     rt field of the instruction in ID
// - id_rd_i        in   RA_W     rd field of the instruction in ID
// - branch_taken_i in   1        ID-stage comparator: taken beq (Branch & equal)
// - jump_i         in   1        ID-stage Jump bit
// - ex_RegDst_o    out  1        EX-stage control
// - ex_ALUSrc_o    out  1        EX-stage control
// - ex_ALUOp_o     out  ALUOP_W  EX-stage control
// - mem_MemRead_o  out  1        MEM-stage control
// - mem_MemWrite_o out  1        MEM-stage control
// - wb_RegWrite_o  out  1        WB-stage control
// - wb_MemtoReg_o  out  1        WB-stage control
// - wb_wr_addr_o   out  RA_W     WB destination register
// - ForwardA_o     out  2        EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
// - ForwardB_o     out  2        EX operand B select: same encoding
// - pc_write_o     out  1        0 = hold PC
// - ifid_write_o   out  1        0 = hold IF/ID
// - ifid_flush_o   out  1        1 = zero IF/ID next edge
// BEHAVIOUR
// - Three registered stages: ID/EX (all bits, plus rs/rt/rd), EX/MEM (MemRead, MemWrite, RegWrite, MemtoReg, wr_addr), MEM/WB (RegWrite, MemtoReg, wr_addr).
// - Each stage advances every cycle; there is no global enable.
// - rst_i asserted (async): every stage register goes to 0, so all ex_/mem_/wb_ outputs are 0. Reset mid-operation discards all in-flight instructions.
// - wr_addr is computed in EX as RegDst ? rd : rt and captured into EX/MEM. An X RegDst with RegWrite=0 is harmless.
// - Latency: a bundle presented in ID cycle n appears on ex_ outputs at n+1, mem_ at n+2, wb_ at n+3.
// - Load-use stall (combinational): stall = ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
//   On stall: pc_write_o = 0, ifid_write_o = 0, and ID/EX captures an all-zero bubble. Exactly one bubble is inserted per load-use.
// - Flush: ifid_flush_o = (branch_taken_i | jump_i) & ~stall. Stall has priority; the branch re-evaluates next cycle with forwarded data.
// - Forwarding, A side (B identical with ex_rt):
//   - 10 if mem_RegWrite & mem_wr != 0 & mem_wr == ex_rs;
//   - else 01 if wb_RegWrite & wb_wr != 0 & wb_wr == ex_rs;
//   - else 00.
//   EX/MEM wins when both stages match.
// - Writes to $0 are never forwarded. wb_RegWrite_o with wb_wr_addr_o = 0 is legal; the regfile ignores it.
// - Reset/idle outputs: pc_write_o = 1, ifid_write_o = 1, ifid_flush_o = 0, ForwardA/B = 00.
// STRUCTURE
// - Shared header ctrl_defs.vh holds:
//   - bit-position localparams of the 10-bit control bundle {RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, MemRead, Branch, Jump, ALUOp}, identical to the decoder's packing;
//   - FWD_REG = 2'b00, FWD_EXMEM = 2'b10, FWD_MEMWB = 2'b01.
// - One sub-module, fwd_unit (purely combinational forwarding selects), instantiated once.
// - Stage registers and hazard/flush logic live in ctrl_pipe.
// TESTING
// - Reset: drive rst_i mid-stream with RegWrite=1 in all stages -> all stage outputs 0 immediately, without waiting for a clock edge.
// - Pipeline latency: addi bundle (RegWrite=1, ALUSrc=1, ALUOp=01, rt=8) -> ex_ALUSrc=1 at +1, wb_RegWrite=1 with wb_wr_addr=8 at +3.
// - Load-use: lw rt=9 followed by add rs=9 -> one cycle with pc_write=0, ifid_write=0; then a zero bubble appears at ex_; add reaches EX next cycle with ForwardA=01.
// - Forward priority: add rd=5, add rd=5, add rs=5 rt=5 -> third instruction in EX sees ForwardA=10, ForwardB=10.
// - $0: add rd=0 followed by add rs=0 -> ForwardA=00; lw rt=0 followed by a use of $0 -> no stall.
// - Flush: branch_taken=1 with no stall -> ifid_flush=1 for one cycle. Same cycle with a load-use -> flush=0 and the stall is taken first.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline: control-bundle bit
// positions (same packing as the main decoder) and forwarding selects.
package ctrl_pipe_pkg;

   localparam int CTRL_W      = 10;
   localparam int CB_REGDST   = 9;
   localparam int CB_ALUSRC   = 8;
   localparam int CB_MEMTOREG = 7;
   localparam int CB_REGWRITE = 6;
   localparam int CB_MEMWRITE = 5;
   localparam int CB_MEMREAD  = 4;
   localparam int CB_BRANCH   = 3;
   localparam int CB_JUMP     = 2;
   localparam int CB_ALUOP_HI = 1;
   localparam int CB_ALUOP_LO = 0;

   localparam logic [1:0] FWD_REG   = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/ctrl_pipe_fwd_unit.sv
// EX-stage operand forwarding selects; EX/MEM result beats MEM/WB.
module fwd_unit
   import ctrl_pipe_pkg::*;
#(
   parameter int RA_W = 5
) (
   input  logic [RA_W-1:0] ex_rs_i,
   input  logic [RA_W-1:0] ex_rt_i,
   input  logic            mem_reg_write_i,
   input  logic [RA_W-1:0] mem_wr_i,
   input  logic            wb_reg_write_i,
   input  logic [RA_W-1:0] wb_wr_i,
   output logic [1:0]      fwd_a_o,
   output logic [1:0]      fwd_b_o
);

   logic mem_ok;
   logic wb_ok;

   // $0 is hard-wired, so a write to it is never a forwarding source
   assign mem_ok = mem_reg_write_i & (mem_wr_i != '0);
   assign wb_ok  = wb_reg_write_i & (wb_wr_i != '0);

   always_comb begin
      fwd_a_o = FWD_REG;
      fwd_b_o = FWD_REG;
      if (mem_ok && (mem_wr_i == ex_rs_i))
         fwd_a_o = FWD_EXMEM;
      else if (wb_ok && (wb_wr_i == ex_rs_i))
         fwd_a_o = FWD_MEMWB;
      if (mem_ok && (mem_wr_i == ex_rt_i))
         fwd_b_o = FWD_EXMEM;
      else if (wb_ok && (wb_wr_i == ex_rt_i))
         fwd_b_o = FWD_MEMWB;
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline ID->EX->MEM->WB with load-use stall,
// branch/jump IF/ID flush and EX operand forwarding selects.
module ctrl_pipe
   import ctrl_pipe_pkg::*;
#(
   parameter int RA_W    = 5,
   parameter int ALUOP_W = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               RegDst_i,
   input  logic               ALUSrc_i,
   input  logic               MemtoReg_i,
   input  logic               RegWrite_i,
   input  logic               MemWrite_i,
   input  logic               MemRead_i,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [RA_W-1:0]    id_rs_i,
   input  logic [RA_W-1:0]    id_rt_i,
   input  logic [RA_W-1:0]    id_rd_i,
   input  logic               branch_taken_i,
   input  logic               jump_i,
   output logic               ex_RegDst_o,
   output logic               ex_ALUSrc_o,
   output logic [ALUOP_W-1:0] ex_ALUOp_o,
   output logic               mem_MemRead_o,
   output logic               mem_MemWrite_o,
   output logic               wb_RegWrite_o,
   output logic               wb_MemtoReg_o,
   output logic [RA_W-1:0]    wb_wr_addr_o,
   output logic [1:0]         ForwardA_o,
   output logic [1:0]         ForwardB_o,
   output logic               pc_write_o,
   output logic               ifid_write_o,
   output logic               ifid_flush_o
);

   typedef struct packed {
      logic               reg_dst;
      logic               alu_src;
      logic               mem_to_reg;
      logic               reg_write;
      logic               mem_write;
      logic               mem_read;
      logic [ALUOP_W-1:0] alu_op;
      logic [RA_W-1:0]    rs;
      logic [RA_W-1:0]    rt;
      logic [RA_W-1:0]    rd;
   } id_ex_t;

   typedef struct packed {
      logic            mem_read;
      logic            mem_write;
      logic            reg_write;
      logic            mem_to_reg;
      logic [RA_W-1:0] wr_addr;
   } ex_mem_t;

   typedef struct packed {
      logic            reg_write;
      logic            mem_to_reg;
      logic [RA_W-1:0] wr_addr;
   } mem_wb_t;

   id_ex_t  idex_d,  idex_q;
   ex_mem_t exmem_d, exmem_q;
   mem_wb_t memwb_d, memwb_q;
   logic    stall;

   assign stall = idex_q.mem_read & (idex_q.rt != '0) &
                  ((idex_q.rt == id_rs_i) | (idex_q.rt == id_rt_i));

   always_comb begin
      idex_d = '0;
      if (!stall) begin
         idex_d.reg_dst    = RegDst_i;
         idex_d.alu_src    = ALUSrc_i;
         idex_d.mem_to_reg = MemtoReg_i;
         idex_d.reg_write  = RegWrite_i;
         idex_d.mem_write  = MemWrite_i;
         idex_d.mem_read   = MemRead_i;
         idex_d.alu_op     = ALUOp_i;
         idex_d.rs         = id_rs_i;
         idex_d.rt         = id_rt_i;
         idex_d.rd         = id_rd_i;
      end
   end

   always_comb begin
      exmem_d            = '0;
      exmem_d.mem_read   = idex_q.mem_read;
      exmem_d.mem_write  = idex_q.mem_write;
      exmem_d.reg_write  = idex_q.reg_write;
      exmem_d.mem_to_reg = idex_q.mem_to_reg;
      exmem_d.wr_addr    = idex_q.reg_dst ? idex_q.rd : idex_q.rt;
      memwb_d            = '0;
      memwb_d.reg_write  = exmem_q.reg_write;
      memwb_d.mem_to_reg = exmem_q.mem_to_reg;
      memwb_d.wr_addr    = exmem_q.wr_addr;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
      end
   end

   fwd_unit #(.RA_W(RA_W)) u_fwd (
      .ex_rs_i         (idex_q.rs),
      .ex_rt_i         (idex_q.rt),
      .mem_reg_write_i (exmem_q.reg_write),
      .mem_wr_i        (exmem_q.wr_addr),
      .wb_reg_write_i  (memwb_q.reg_write),
      .wb_wr_i         (memwb_q.wr_addr),
      .fwd_a_o         (ForwardA_o),
      .fwd_b_o         (ForwardB_o)
   );

   // stall wins: the branch re-resolves next cycle with forwarded data
   assign ifid_flush_o   = (branch_taken_i | jump_i) & ~stall;
   assign pc_write_o     = ~stall;
   assign ifid_write_o   = ~stall;

   assign ex_RegDst_o    = idex_q.reg_dst;
   assign ex_ALUSrc_o    = idex_q.alu_src;
   assign ex_ALUOp_o     = idex_q.alu_op;
   assign mem_MemRead_o  = exmem_q.mem_read;
   assign mem_MemWrite_o = exmem_q.mem_write;
   assign wb_RegWrite_o  = memwb_q.reg_write;
   assign wb_MemtoReg_o  = memwb_q.mem_to_reg;
   assign wb_wr_addr_o   = memwb_q.wr_addr;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe.
module tb_ctrl_pipe;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       RegDst_i, ALUSrc_i, MemtoReg_i, RegWrite_i;
   logic       MemWrite_i, MemRead_i;
   logic [1:0] ALUOp_i;
   logic [4:0] id_rs_i, id_rt_i, id_rd_i;
   logic       branch_taken_i, jump_i;
   logic       ex_RegDst_o, ex_ALUSrc_o;
   logic [1:0] ex_ALUOp_o;
   logic       mem_MemRead_o, mem_MemWrite_o;
   logic       wb_RegWrite_o, wb_MemtoReg_o;
   logic [4:0] wb_wr_addr_o;
   logic [1:0] ForwardA_o, ForwardB_o;
   logic       pc_write_o, ifid_write_o, ifid_flush_o;

   int tests = 0;
   int fails = 0;

   always #5 clk_i = ~clk_i;

   ctrl_pipe dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .RegDst_i(RegDst_i), .ALUSrc_i(ALUSrc_i),
      .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
      .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
      .ALUOp_i(ALUOp_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i),
      .ex_RegDst_o(ex_RegDst_o), .ex_ALUSrc_o(ex_ALUSrc_o),
      .ex_ALUOp_o(ex_ALUOp_o),
      .mem_MemRead_o(mem_MemRead_o), .mem_MemWrite_o(mem_MemWrite_o),
      .wb_RegWrite_o(wb_RegWrite_o), .wb_MemtoReg_o(wb_MemtoReg_o),
      .wb_wr_addr_o(wb_wr_addr_o),
      .ForwardA_o(ForwardA_o), .ForwardB_o(ForwardB_o),
      .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
      .ifid_flush_o(ifid_flush_o)
   );

   // regdst, alusrc, memtoreg, regwrite, memwrite, memread, aluop, rs, rt, rd
   task automatic set_id(input logic rdst, input logic asrc,
                         input logic m2r, input logic rw,
                         input logic mw, input logic mr,
                         input logic [1:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
      RegDst_i = rdst; ALUSrc_i = asrc; MemtoReg_i = m2r;
      RegWrite_i = rw; MemWrite_i = mw; MemRead_i = mr;
      ALUOp_i = op; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
   endtask

   task automatic nop();
      set_id(0, 0, 0, 0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain();
      nop();
      branch_taken_i = 0;
      jump_i = 0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      rst_i = 1;
      nop();
      branch_taken_i = 0;
      jump_i = 0;
      #2;
      tests++;
      if ({ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, mem_MemRead_o,
           mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o,
           wb_wr_addr_o} !== 13'd0) begin
         fails++;
         $display("FAIL reset_stage_outs got=%b want=0",
                  {ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, mem_MemRead_o,
                   mem_MemWrite_o, wb_RegWrite_o, wb_MemtoReg_o,
                   wb_wr_addr_o});
      end
      tests++;
      if ({pc_write_o, ifid_write_o, ifid_flush_o,
           ForwardA_o, ForwardB_o} !== 7'b1100000) begin
         fails++;
         $display("FAIL reset_ctrl_outs got=%b want=1100000",
                  {pc_write_o, ifid_write_o, ifid_flush_o,
                   ForwardA_o, ForwardB_o});
      end
      @(negedge clk_i);
      rst_i = 0;
      step();
   endtask

   task automatic test_latency();
      drain();
      set_id(0, 1, 0, 1, 0, 0, 2'b01, 5'd1, 5'd8, 5'd3);
      step();
      nop();
      tests++;
      if ({ex_ALUSrc_o, ex_ALUOp_o} !== 3'b101) begin
         fails++;
         $display("FAIL lat_ex got=%b want=101", {ex_ALUSrc_o, ex_ALUOp_o});
      end
      step();
      tests++;
      if (wb_RegWrite_o !== 1'b0) begin
         fails++;
         $display("FAIL lat_wb_early got=%b want=0", wb_RegWrite_o);
      end
      step();
      tests++;
      if ({wb_RegWrite_o, wb_wr_addr_o} !== {1'b1, 5'd8}) begin
         fails++;
         $display("FAIL lat_wb got=%b/%0d want=1/8",
                  wb_RegWrite_o, wb_wr_addr_o);
      end
   endtask

   task automatic test_reset_mid();
      drain();
      set_id(1, 1, 0, 1, 0, 0, 2'b10, 5'd1, 5'd2, 5'd7);
      repeat (3) step();
      tests++;
      if ({wb_RegWrite_o, wb_wr_addr_o, ex_ALUSrc_o} !== {1'b1, 5'd7, 1'b1}) begin
         fails++;
         $display("FAIL rstmid_pre got=%b/%0d/%b want=1/7/1",
                  wb_RegWrite_o, wb_wr_addr_o, ex_ALUSrc_o);
      end
      rst_i = 1;
      #1;
      tests++;
      if ({wb_RegWrite_o, wb_wr_addr_o, ex_ALUSrc_o, ex_ALUOp_o,
           ex_RegDst_o} !== 10'd0) begin
         fails++;
         $display("FAIL rstmid_async got=%b/%0d/%b/%b/%b want=0",
                  wb_RegWrite_o, wb_wr_addr_o, ex_ALUSrc_o,
                  ex_ALUOp_o, ex_RegDst_o);
      end
      nop();
      @(negedge clk_i);
      rst_i = 0;
      step();
   endtask

   task automatic test_load_use();
      drain();
      set_id(0, 1, 1, 1, 0, 1, 2'b00, 5'd2, 5'd9, 5'd0);
      step();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd9, 5'd3, 5'd10);
      #1;
      tests++;
      if ({pc_write_o, ifid_write_o} !== 2'b00) begin
         fails++;
         $display("FAIL lu_stall got=%b want=00", {pc_write_o, ifid_write_o});
      end
      step();
      tests++;
      if ({ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, pc_write_o,
           mem_MemRead_o} !== 6'b000011) begin
         fails++;
         $display("FAIL lu_bubble got=%b want=000011",
                  {ex_RegDst_o, ex_ALUSrc_o, ex_ALUOp_o, pc_write_o,
                   mem_MemRead_o});
      end
      step();
      nop();
      tests++;
      if ({ex_RegDst_o, ex_ALUOp_o, ForwardA_o, ForwardB_o} !== 7'b1100100) begin
         fails++;
         $display("FAIL lu_fwd got=%b/%b/%b/%b want=1/10/01/00",
                  ex_RegDst_o, ex_ALUOp_o, ForwardA_o, ForwardB_o);
      end
   endtask

   task automatic test_fwd_priority();
      drain();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd1, 5'd2, 5'd5);
      step();
      step();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd5, 5'd5, 5'd6);
      step();
      tests++;
      if ({ForwardA_o, ForwardB_o} !== 4'b1010) begin
         fails++;
         $display("FAIL fwd_prio got=%b/%b want=10/10",
                  ForwardA_o, ForwardB_o);
      end
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd6, 5'd5, 5'd4);
      step();
      nop();
      tests++;
      if ({ForwardA_o, ForwardB_o} !== 4'b1001) begin
         fails++;
         $display("FAIL fwd_mix got=%b/%b want=10/01",
                  ForwardA_o, ForwardB_o);
      end
   endtask

   task automatic test_zero_reg();
      drain();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd1, 5'd2, 5'd0);
      step();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd0, 5'd0, 5'd3);
      step();
      nop();
      tests++;
      if ({ForwardA_o, ForwardB_o} !== 4'b0000) begin
         fails++;
         $display("FAIL zero_fwd got=%b/%b want=00/00",
                  ForwardA_o, ForwardB_o);
      end
      set_id(0, 1, 1, 1, 0, 1, 2'b00, 5'd2, 5'd0, 5'd0);
      step();
      set_id(1, 0, 0, 1, 0, 0, 2'b10, 5'd0, 5'd0, 5'd11);
      #1;
      tests++;
      if ({pc_write_o, ifid_write_o} !== 2'b11) begin
         fails++;
         $display("FAIL zero_nostall got=%b want=11",
                  {pc_write_o, ifid_write_o});
      end
   endtask

   task automatic test_flush();
      drain();
      branch_taken_i = 1;
      #1;
      tests++;
      if (ifid_flush_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_br got=%b want=1", ifid_flush_o);
      end
      step();
      branch_taken_i = 0;
      #1;
      tests++;
      if (ifid_flush_o !== 1'b0) begin
         fails++;
         $display("FAIL flush_clr got=%b want=0", ifid_flush_o);
      end
      jump_i = 1;
      #1;
      tests++;
      if (ifid_flush_o !== 1'b1) begin
         fails++;
         $display("FAIL flush_jmp got=%b want=1", ifid_flush_o);
      end
      jump_i = 0;
      set_id(0, 1, 1, 1, 0, 1, 2'b00, 5'd2, 5'd9, 5'd0);
      step();
      set_id(0, 0, 0, 0, 0, 0, 2'b01, 5'd9, 5'd4, 5'd0);
      branch_taken_i = 1;
      #1;
      tests++;
      if ({ifid_flush_o, pc_write_o} !== 2'b00) begin
         fails++;
         $display("FAIL flush_vs_stall got=%b want=00",
                  {ifid_flush_o, pc_write_o});
      end
      step();
      tests++;
      if ({ifid_flush_o, pc_write_o} !== 2'b11) begin
         fails++;
         $display("FAIL flush_after got=%b want=11",
                  {ifid_flush_o, pc_write_o});
      end
      branch_taken_i = 0;
   endtask

   initial begin
      test_reset();
      test_latency();
      test_reset_mid();
      test_load_use();
      test_fwd_priority();
      test_zero_reg();
      test_flush();
      drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
